// File: rtl/booth_mul_pkg.sv
// booth_mul_pkg: shared FSM states, Booth digit codes and sizing helpers for booth_mul_seq
package booth_mul_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} digit_e;
  function automatic int iter_count(input int width);
    return (width + 3) / 2;
  endfunction
  function automatic digit_e booth_decode(input logic [2:0] t);
    return (t == 3'b011) ? POS2 :
           (t == 3'b100) ? NEG2 :
           (t == 3'b001 || t == 3'b010) ? POS1 :
           (t == 3'b101 || t == 3'b110) ? NEG1 : ZERO;
  endfunction
endpackage

// File: rtl/booth_r4_digit.sv
// booth_r4_digit: radix-4 Booth partial product (0, +-A, +-2A) for one recoded triplet
//   triplet : {b[2i+1], b[2i], b[2i-1]}
//   a_ext   : multiplicand extended to WIDTH+2 bits
//   pp      : signed partial product, WIDTH+3 bits
module booth_r4_digit
  import booth_mul_pkg::*;
#(
  parameter int WIDTH = 11
) (
  input  logic [2:0]       triplet,
  input  logic [WIDTH+1:0] a_ext,
  output logic [WIDTH+2:0] pp
);
  digit_e digit;
  logic [WIDTH+2:0] a1, a2;
  always_comb begin
    digit = booth_decode(triplet);
    a1 = {a_ext[WIDTH+1], a_ext};
    a2 = {a_ext, 1'b0};
    pp = (digit == POS1) ? a1 :
         (digit == POS2) ? a2 :
         (digit == NEG1) ? -a1 :
         (digit == NEG2) ? -a2 : '0;
  end
endmodule

// File: rtl/booth_mul_seq.sv
// booth_mul_seq: sequential radix-4 Booth multiplier, one digit per enabled cycle
//   clk, rst (sync, active-high), en (clock enable)
//   in_valid/in_ready/is_signed/A/B : operand handshake
//   out_valid/out_ready/P           : product handshake, P is 2*WIDTH bits
module booth_mul_seq
  import booth_mul_pkg::*;
#(
  parameter int WIDTH = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] P
);
  localparam int ITER = iter_count(WIDTH);
  localparam int LW   = 2 * ITER;
  localparam int HW   = WIDTH + 4;
  localparam int PW   = 2 * WIDTH;
  localparam int CW   = $clog2(ITER);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH+1:0] a_q, a_d;
  logic [HW-1:0] hi_q, hi_d, sum, hi_n;
  logic [LW-1:0] lo_q, lo_d, lo_n;
  logic bm1_q, bm1_d;
  logic [PW-1:0] p_q, p_d;
  logic [WIDTH+2:0] pp;
  booth_r4_digit #(.WIDTH(WIDTH)) u_digit (
    .triplet({lo_q[1:0], bm1_q}),
    .a_ext  (a_q),
    .pp     (pp)
  );
  // {hi, lo} is a combined accumulator/multiplier register: the high half
  // takes the partial product, then the pair shifts right arithmetically by
  // one digit so product bits replace retired multiplier bits in lo.
  always_comb begin
    sum  = hi_q + {pp[WIDTH+2], pp};
    hi_n = {{2{sum[HW-1]}}, sum[HW-1:2]};
    lo_n = {sum[1:0], lo_q[LW-1:2]};
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    bm1_d   = bm1_q;
    p_d     = p_q;
    if (en) begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_d     = {{2{is_signed & A[WIDTH-1]}}, A};
          lo_d    = {{(LW-WIDTH){is_signed & B[WIDTH-1]}}, B};
          hi_d    = '0;
          bm1_d   = 1'b0;
          cnt_d   = '0;
          state_d = CALC;
        end
        CALC: begin
          hi_d  = hi_n;
          lo_d  = lo_n;
          bm1_d = lo_q[1];
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(ITER - 1)) begin
            cnt_d   = '0;
            p_d     = PW'({hi_n, lo_n});
            state_d = DONE;
          end
        end
        DONE: if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      bm1_q   <= 1'b0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      bm1_q   <= bm1_d;
      p_q     <= p_d;
    end
  end
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign P         = p_q;
endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: directed and random checks of booth_mul_seq against an arithmetic model
module tb_booth_mul_seq;
  localparam int W  = 11;
  localparam int PW = 2 * W;
  localparam int IT = (W + 3) / 2;
  logic clk = 1'b0;
  logic rst, en, in_valid, in_ready, is_signed, out_valid, out_ready;
  logic [W-1:0] a, b;
  logic [PW-1:0] p, held;
  int errors = 0;
  int checks = 0;
  booth_mul_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .is_signed(is_signed), .A(a), .B(b), .out_valid(out_valid),
    .out_ready(out_ready), .P(p)
  );
  always #5 clk = ~clk;
  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    longint xv, yv;
    xv = s ? longint'($signed(x)) : longint'(x);
    yv = s ? longint'($signed(y)) : longint'(y);
    return PW'(xv * yv);
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                    input int stall_at, input int stall_len, input string tag);
    int lat;
    logic [PW-1:0] exp;
    exp = ref_mul(x, y, s);
    a = x;
    b = y;
    is_signed = s;
    in_valid = 1'b1;
    chk({tag, "_ready_idle"}, 64'(in_ready), 64'(1));
    tick;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    is_signed = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 200) begin
      if (lat == stall_at) en = 1'b0;
      if (lat == stall_at + stall_len) en = 1'b1;
      tick;
      lat++;
      if (!out_valid) chk({tag, "_ready_calc"}, 64'(in_ready), 64'(0));
    end
    en = 1'b1;
    chk({tag, "_latency"}, 64'(lat), 64'(IT + stall_len));
    chk({tag, "_p"}, 64'(p), 64'(exp));
    chk({tag, "_ready_done"}, 64'(in_ready), 64'(0));
    if (out_ready) begin
      tick;
      chk({tag, "_valid_clr"}, 64'(out_valid), 64'(0));
    end
  endtask
  initial begin
    rst = 1'b1;
    en = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    is_signed = 1'b0;
    a = '0;
    b = '0;
    tick;
    tick;
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_p", 64'(p), 64'(0));
    op(11'h400, 11'h400, 1'b1, -1, 0, "smin");
    chk("smin_const", 64'(p), 64'(1048576));
    op(11'h7FF, 11'h7FF, 1'b0, -1, 0, "umax");
    chk("umax_const", 64'(p), 64'(4190209));
    op(11'h7FF, 11'h7FF, 1'b1, -1, 0, "sm1");
    chk("sm1_const", 64'(p), 64'(1));
    op(11'h7FF, 11'h001, 1'b1, -1, 0, "sm1x1");
    chk("sm1x1_const", 64'(p), 64'(22'h3FFFFF));
    op(11'h000, 11'h5A5, 1'b0, -1, 0, "azero");
    chk("azero_const", 64'(p), 64'(0));
    op(11'h6C3, 11'h000, 1'b1, -1, 0, "bzero");
    chk("bzero_const", 64'(p), 64'(0));
    for (int i = 0; i < 150; i++) op(W'($urandom), W'($urandom), 1'b1, -1, 0, "rnd_s");
    for (int i = 0; i < 150; i++) op(W'($urandom), W'($urandom), 1'b0, -1, 0, "rnd_u");
    out_ready = 1'b0;
    op(11'h3A1, 11'h4F2, 1'b1, -1, 0, "bp");
    held = p;
    for (int i = 0; i < 20; i++) begin
      tick;
      chk("bp_p_hold", 64'(p), 64'(held));
      chk("bp_valid_hold", 64'(out_valid), 64'(1));
      chk("bp_ready_low", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    tick;
    chk("bp_release_valid", 64'(out_valid), 64'(0));
    chk("bp_release_ready", 64'(in_ready), 64'(1));
    a = 11'h123;
    b = 11'h321;
    is_signed = 1'b0;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort_ready", 64'(in_ready), 64'(1));
    chk("abort_valid", 64'(out_valid), 64'(0));
    chk("abort_p", 64'(p), 64'(0));
    for (int i = 0; i < IT + 2; i++) tick;
    chk("abort_no_valid", 64'(out_valid), 64'(0));
    op(W'($urandom), W'($urandom), 1'b1, -1, 0, "post_abort");
    op(11'h5B7, 11'h29C, 1'b1, 2, 5, "stall_s");
    op(11'h7F0, 11'h6E1, 1'b0, 4, 5, "stall_u");
    en = 1'b0;
    a = 11'h011;
    b = 11'h022;
    in_valid = 1'b1;
    tick;
    tick;
    chk("en0_no_accept", 64'(in_ready), 64'(1));
    in_valid = 1'b0;
    en = 1'b1;
    tick;
    chk("en0_still_idle", 64'(in_ready), 64'(1));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/booth_mul_seq.md
Name: booth_mul_seq

Overview:
- Parametrised sequential radix-4 Booth multiplier; successor to the fixed-width single-cycle signed multipliers in the binary multiplier family.
- Multiplies two WIDTH-bit operands as signed or unsigned, selected per transaction.
- Retires one Booth digit per cycle, with valid/ready handshakes on both input and output.
- Sits between operand producers and accumulate/compare logic that can apply backpressure.

Parameters:
WIDTH, 11, operand width in bits (>= 2)
ITER, ceil((WIDTH+2)/2), Booth digits per product; derived localparam, not overridable

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
en  in  1  clock enable; when 0 all state and outputs hold
in_valid  in  1  operands present
in_ready  out  1  block can accept operands
is_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with A/B
A  in  WIDTH  multiplicand
B  in  WIDTH  multiplier
out_valid  out  1  P holds a completed product
out_ready  in  1  consumer takes P
P  out  2*WIDTH  product; signed mode sign-extended to 2*WIDTH

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: when rst=1 at an edge, regardless of en: state=IDLE, out_valid=0, P=0, iteration counter=0.
  - in_ready is (state==IDLE), so it is 1 from the first cycle after reset.
  - Reset mid-operation aborts the product; no out_valid is produced for it.
- en=0: all registers hold, including the FSM, counter, partial product and P. Handshakes are not taken while en=0.
- State machine:
  - IDLE: in_ready=1. On in_valid & en, latch A, B and is_signed; clear the accumulator and counter; go to CALC.
  - CALC: in_ready=0. Each enabled cycle, decode one Booth digit of B, add it to the accumulator, and shift. The counter runs 0..ITER-1; on the edge where counter==ITER-1, write P and go to DONE.
  - DONE: out_valid=1; P is stable. On out_ready & en, clear out_valid and go to IDLE.
  - There is no same-cycle re-accept in DONE; the next operand is accepted in IDLE, one cycle later at the earliest.
- Latency: out_valid rises exactly ITER enabled cycles after the accepting edge (7 for WIDTH=11). Back-to-back throughput is one product per ITER+2 cycles.
- Arithmetic:
  - Extend operands to WIDTH+2 bits: sign-extend when is_signed=1, zero-extend when is_signed=0. This keeps unsigned top bits correct under Booth recoding.
  - Booth recoding of B uses triplets {b[2i+1], b[2i], b[2i-1]} with b[-1]=0, giving digits in {-2,-1,0,+1,+2}.
  - The accumulator is wide enough for the exact product; P is truncated to 2*WIDTH bits, which is lossless for both modes.
- Boundaries:
  - Signed corner: -2^(WIDTH-1) * -2^(WIDTH-1) = +2^(2*WIDTH-2) is exact.
  - Unsigned corner: (2^WIDTH-1)^2 fits 2*WIDTH bits.
  - A=0 or B=0 gives P=0.
  - Changes on A, B or is_signed while the block is not in IDLE are ignored.
  - out_ready held low keeps DONE, P and out_valid indefinitely.

Decomposition:
- Package booth_mul_pkg holds:
  - FSM state encoding (IDLE, CALC, DONE);
  - Booth digit encoding (ZERO, POS1, POS2, NEG1, NEG2);
  - function iter_count(width) = ceil((width+2)/2).
- Sub-module booth_r4_digit: combinational; inputs are a 3-bit triplet and the extended multiplicand; output is the signed partial product (±A, ±2A or 0), width WIDTH+3.
- booth_mul_seq owns the FSM, counter, accumulator and shift register.

Test Plan:
- Reset, then signed A=-1024, B=-1024 with out_ready=1 -> out_valid exactly 7 cycles after accept, P=22'd1048576; in_ready low throughout CALC/DONE.
- is_signed=0, A=2047, B=2047 -> P=22'd4190209. Then is_signed=1 on the same bits (-1 * -1) -> P=1.
- Signed A=-1, B=1 -> P=22'h3FFFFF. Exhaustive signed and unsigned sweep over all 2^22 pairs for WIDTH=11 against a reference model -> zero mismatches.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> P and out_valid stable, in_ready=0. Then out_ready=1 -> out_valid=0 next cycle, in_ready=1.
- Assert rst during CALC (cycle 3) -> next cycle state IDLE, out_valid=0, P=0; a new operand pair then completes correctly.
- en=0 for 5 cycles mid-CALC -> latency extends by exactly 5 cycles and the product stays correct. Regression at WIDTH=4 and WIDTH=16 with a random sweep.
